// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, FSM states
// and the accumulate mode applied to a finished product.
package hilo_muldiv_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MULTU = 3'd0;
  localparam op_t OP_MULT  = 3'd1;
  localparam op_t OP_MTHI  = 3'd2;
  localparam op_t OP_MTLO  = 3'd3;
  localparam op_t OP_MADD  = 3'd4;
  localparam op_t OP_MSUB  = 3'd5;
  localparam op_t OP_DIVU  = 3'd6;
  localparam op_t OP_DIV   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_op_e;

endpackage

// File: rtl/hilo_iter_engine.sv
// Iterative unsigned datapath: shift-add multiplier or restoring divider, retiring
// BITS_PER_CYCLE bits per step for N = WIDTH/BITS_PER_CYCLE steps after start.
module hilo_iter_engine #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]      cnt;
  logic               mode_q;
  // mul: a_q = shifting multiplicand, x_q = multiplier, acc_q = partial product
  // div: a_q = divisor, x_q = dividend shifting into quotient, acc_q = remainder
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH:0]     rem;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred; blocking '=' is intended because each
  // loop iteration builds on the previous one within the same step.
  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    x_d   = x_q;
    rem   = acc_q[WIDTH:0];
    if (!mode_q) begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        if (x_q[i]) acc_d = acc_d + (a_q << i);
      end
      a_d = a_q << BITS_PER_CYCLE;
      x_d = x_q >> BITS_PER_CYCLE;
    end else begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        rem = {rem[WIDTH-1:0], x_d[WIDTH-1]};
        x_d = {x_d[WIDTH-2:0], 1'b0};
        if (rem >= {1'b0, a_q[WIDTH-1:0]}) begin
          rem    = rem - {1'b0, a_q[WIDTH-1:0]};
          x_d[0] = 1'b1;
        end
      end
      acc_d = {{(WIDTH-1){1'b0}}, rem};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst)                cnt <= '0;
    else if (start)          cnt <= CW'(N);
    else if (cnt != '0)      cnt <= cnt - CW'(1);
  end

  // NOTE: datapath registers carry no reset; they are fully loaded on start and
  // only read after the counter (which is reset) has run down.
  always_ff @(posedge Clk) begin
    if (start) begin
      mode_q <= div_mode;
      a_q    <= {{WIDTH{1'b0}}, (div_mode ? opnd_b : opnd_a)};
      x_q    <= div_mode ? opnd_a : opnd_b;
      acc_q  <= '0;
    end else if (cnt != '0) begin
      a_q   <= a_d;
      x_q   <= x_d;
      acc_q <= acc_d;
    end
  end

  assign last   = (cnt == CW'(1));
  assign res_hi = mode_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
  assign res_lo = mode_q ? x_q : acc_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULT/MULTU/MADD/MSUB and MTHI/MTLO.
// Define HILO_MULDIV_DIV_EN to add DIV/DIVU; otherwise ops 6/7 are one-cycle no-ops.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               accept, is_iter_op, is_signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               eng_start, eng_div, eng_last;
  logic [WIDTH-1:0]   eng_hi, eng_lo;
  logic               res_neg_q;
  acc_op_e            acc_op_q;
  logic [2*WIDTH-1:0] prod, prod_s, wr_hilo;

  assign op_ready = (state_q == ST_IDLE) && Rst;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign HI_out   = hi_q;
  assign LO_out   = lo_q;
  assign accept   = op_valid && op_ready;

  assign is_signed_op = op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
`ifdef HILO_MULDIV_DIV_EN
  logic is_div_q, rem_neg_q;
  assign is_iter_op = !(op inside {OP_MTHI, OP_MTLO});
  assign eng_div    = op inside {OP_DIVU, OP_DIV};
`else
  assign is_iter_op = op inside {OP_MULTU, OP_MULT, OP_MADD, OP_MSUB};
  assign eng_div    = 1'b0;
`endif

  assign sign_a    = is_signed_op && src_a[WIDTH-1];
  assign sign_b    = is_signed_op && src_b[WIDTH-1];
  assign mag_a     = sign_a ? -src_a : src_a;
  assign mag_b     = sign_b ? -src_b : src_b;
  assign eng_start = accept && is_iter_op;

  hilo_iter_engine #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_engine (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (eng_start),
    .div_mode(eng_div),
    .opnd_a  (mag_a),
    .opnd_b  (mag_b),
    .last    (eng_last),
    .res_hi  (eng_hi),
    .res_lo  (eng_lo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (eng_start) state_d = ST_RUN;
      ST_RUN:   if (eng_last)  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // HI/LO are frozen while busy, so they double as the MADD/MSUB accumulator.
  assign prod   = {eng_hi, eng_lo};
  assign prod_s = res_neg_q ? -prod : prod;

  always_comb begin
    case (acc_op_q)
      ACC_ADD: wr_hilo = {hi_q, lo_q} + prod_s;
      ACC_SUB: wr_hilo = {hi_q, lo_q} - prod_s;
      default: wr_hilo = prod_s;
    endcase
`ifdef HILO_MULDIV_DIV_EN
    if (is_div_q) begin
      wr_hilo[WIDTH-1:0]       = res_neg_q ? -eng_lo : eng_lo;
      wr_hilo[2*WIDTH-1:WIDTH] = rem_neg_q ? -eng_hi : eng_hi;
    end
`endif
  end

  // A zero divisor keeps the all-ones quotient unsigned; for multiply a zero
  // operand gives zero either way.
  always_ff @(posedge Clk) begin
    if (eng_start) begin
      res_neg_q <= (sign_a ^ sign_b) && (src_b != '0);
      acc_op_q  <= (op == OP_MADD) ? ACC_ADD : (op == OP_MSUB) ? ACC_SUB : ACC_NONE;
`ifdef HILO_MULDIV_DIV_EN
      is_div_q  <= eng_div;
      rem_neg_q <= sign_a;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        case (op)
          OP_MTHI: begin
            hi_q   <= src_a;
            done_q <= 1'b1;
          end
          OP_MTLO: begin
            lo_q   <= src_a;
            done_q <= 1'b1;
          end
`ifdef HILO_MULDIV_DIV_EN
`else
          OP_DIVU, OP_DIV: done_q <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (state_q == ST_WRITE) begin
        hi_q   <= wr_hilo[2*WIDTH-1:WIDTH];
        lo_q   <= wr_hilo[WIDTH-1:0];
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expectations queued at issue, compared on done.
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam int N = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         op_valid = 1'b0;
  op_t          op = OP_MULTU;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         op_ready, busy, done;
  logic [W-1:0] HI_out, LO_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           wait_cyc;
    int           busy_cyc;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] shadow = '0;

  hilo_muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .HI_out  (HI_out),
    .LO_out  (LO_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_iter(input op_t o);
`ifdef HILO_MULDIV_DIV_EN
    return !(o inside {OP_MTHI, OP_MTLO});
`else
    return o inside {OP_MULTU, OP_MULT, OP_MADD, OP_MSUB};
`endif
  endfunction

  function automatic logic [2*W-1:0] model(input op_t o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [2*W-1:0] hl);
    logic signed [2*W-1:0] sp;
    sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    case (o)
      OP_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
      OP_MULT:  return sp;
      OP_MADD:  return hl + sp;
      OP_MSUB:  return hl - sp;
      OP_MTHI:  return {a, hl[W-1:0]};
      OP_MTLO:  return {hl[2*W-1:W], a};
`ifdef HILO_MULDIV_DIV_EN
      OP_DIVU: begin
        if (b == '0) return {a, {W{1'b1}}};
        return {a % b, a / b};
      end
      OP_DIV: begin
        if (b == '0) return {a, {W{1'b1}}};
        if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {{W{1'b0}}, a};
        return {W'($signed(a) % $signed(b)), W'($signed(a) / $signed(b))};
      end
`endif
      default:  return hl;
    endcase
  endfunction

  task automatic push_exp(input op_t o, input logic [2*W-1:0] exp_hilo, input string tag);
    exp_t e;
    e.tag      = tag;
    e.hi       = exp_hilo[2*W-1:W];
    e.lo       = exp_hilo[W-1:0];
    e.wait_cyc = is_iter(o) ? N + 2 : 1;
    e.busy_cyc = is_iter(o) ? N + 1 : 0;
    sb.push_back(e);
    shadow = exp_hilo;
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic issue(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_hilo, input string tag);
    op       = o;
    src_a    = a;
    src_b    = b;
    op_valid = 1'b1;
    check({tag, "/ready"}, op_ready, 1);
    push_exp(o, exp_hilo, tag);
    @(posedge Clk);
    #1 op_valid = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done();
    exp_t e;
    int   cyc = 0, busy_cyc = 0, nrdy_cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
      if (busy) busy_cyc++;
      if (!op_ready) nrdy_cyc++;
    end while (!done && cyc < 200);
    e = sb.pop_front();
    check({e.tag, "/latency"}, 64'(cyc), 64'(e.wait_cyc));
    check({e.tag, "/busy"}, 64'(busy_cyc), 64'(e.busy_cyc));
    check({e.tag, "/not_ready"}, 64'(nrdy_cyc), 64'(e.busy_cyc));
    check({e.tag, "/hi"}, HI_out, e.hi);
    check({e.tag, "/lo"}, LO_out, e.lo);
  endtask

  initial begin
    int   done_seen;
    op_t  ro;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst/hi", HI_out, 0);
    check("rst/lo", LO_out, 0);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/ready_low", op_ready, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // Reset in the middle of a MULT aborts it with no write
    issue(OP_MTHI, 32'hAAAA_5555, '0, {32'hAAAA_5555, 32'h0}, "mthi_pre");
    wait_done();
    issue(OP_MULT, 32'd3, 32'd5, 64'd15, "mult_abort");
    void'(sb.pop_back());
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("abort/hi", HI_out, 0);
    check("abort/lo", LO_out, 0);
    check("abort/busy", busy, 0);
    check("abort/done", done, 0);
    Rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (done) done_seen++;
    end
    check("abort/no_done", 64'(done_seen), 0);
    shadow = '0;
    issue(OP_MTLO, 32'h1234, '0, {32'h0, 32'h0000_1234}, "mtlo_after_rst");
    wait_done();

    // Full-range unsigned multiply and single done pulse
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
    wait_done();
    @(negedge Clk);
    check("multu_max/done_pulse", done, 0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult_neg");
    wait_done();

    // Accumulate chain, issued back-to-back on each done cycle
    issue(OP_MTHI, 32'h0, '0, {32'h0, shadow[W-1:0]}, "acc_mthi");
    wait_done();
    issue(OP_MTLO, 32'd10, '0, {32'h0, 32'd10}, "acc_mtlo");
    wait_done();
    issue(OP_MADD, 32'd4, 32'd5, {32'h0, 32'd30}, "madd");
    wait_done();
    issue(OP_MSUB, 32'd2, 32'd20, {32'hFFFF_FFFF, 32'hFFFF_FFF6}, "msub");
    wait_done();

    // MTHI held while busy is ignored until the done cycle
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, {32'h0000_0001, 32'h0}, "mul_hold");
    op       = OP_MTHI;
    src_a    = 32'hCAFE_F00D;
    op_valid = 1'b1;
    push_exp(OP_MTHI, {32'hCAFE_F00D, 32'h0}, "mthi_held");
    wait_done();
    @(posedge Clk);
    #1 op_valid = 1'b0;
    wait_done();

    // Back-to-back multiplies with no bubble
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, "b2b_1");
    wait_done();
    issue(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, {32'hC000_0000, 32'h8000_0000}, "b2b_2");
    wait_done();

`ifdef HILO_MULDIV_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
    wait_done();
    issue(OP_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_zero");
    wait_done();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_ovf");
    wait_done();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_zero");
    wait_done();
`else
    issue(OP_DIV, 32'd7, 32'd2, shadow, "div_noop");
    wait_done();
    issue(OP_DIVU, 32'd9, 32'd3, shadow, "divu_noop");
    wait_done();
`endif

    // Mixed ops checked against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = op_t'($urandom_range(0, 7));
      ra = $urandom();
      rb = (i == 3) ? '0 : $urandom();
      issue(ro, ra, rb, model(ro, ra, rb, shadow), $sformatf("rand%0d_op%0d", i, ro));
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
